// File: rtl/lsu_ctrl_pipe_if.sv
// Bundle of command, RAM and writeback channels for the load/store control pipe.
// slave = LSU side, master = requester/RAM/writeback environment side.
interface lsu_ctrl_pipe_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_read;
   logic              cmd_write;
   logic              cmd_usign;
   logic [1:0]        cmd_size;
   logic [AW-1:0]     cmd_addr;
   logic [XLEN-1:0]   cmd_wdata;

   logic              ram_req_valid;
   logic              ram_req_ready;
   logic              ram_req_wr;
   logic [AW-1:0]     ram_req_addr;
   logic [XLEN-1:0]   ram_req_wdata;
   logic [XLEN/8-1:0] ram_req_wstrb;
   logic              ram_rsp_valid;
   logic [XLEN-1:0]   ram_rsp_rdata;

   logic              wbck_valid;
   logic              wbck_ready;
   logic [XLEN-1:0]   wbck_wdata;
   logic              wbck_err;
   logic [1:0]        wbck_cause;

   modport slave (
      input  cmd_valid, cmd_read, cmd_write, cmd_usign, cmd_size, cmd_addr, cmd_wdata,
      output cmd_ready,
      output ram_req_valid, ram_req_wr, ram_req_addr, ram_req_wdata, ram_req_wstrb,
      input  ram_req_ready, ram_rsp_valid, ram_rsp_rdata,
      output wbck_valid, wbck_wdata, wbck_err, wbck_cause,
      input  wbck_ready
   );

   modport master (
      output cmd_valid, cmd_read, cmd_write, cmd_usign, cmd_size, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  ram_req_valid, ram_req_wr, ram_req_addr, ram_req_wdata, ram_req_wstrb,
      output ram_req_ready, ram_rsp_valid, ram_rsp_rdata,
      input  wbck_valid, wbck_wdata, wbck_err, wbck_cause,
      output wbck_ready
   );
endinterface

// File: rtl/lsu_ctrl_pipe.sv
// Load/store control pipe: decodes one command, runs RAM request/response
// (optionally read-modify-write), formats load data and hands back a writeback.
module lsu_ctrl_pipe #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned AW       = 32,
   parameter int unsigned RMW_MODE = 0,
   parameter int unsigned TMO      = 15
) (
   input  logic          clk,
   input  logic          rst,
   lsu_ctrl_pipe_if.slave bus
);
   localparam int unsigned NB = XLEN / 8;
   localparam int unsigned OB = $clog2(NB);
   localparam int unsigned CW = $clog2(TMO + 2);

   typedef enum logic [2:0] {IDLE, REQ, RSP, MRG, WB} state_t;

   state_t          state, state_n;
   logic            alive;
   logic [CW-1:0]   cnt;
   logic [1:0]      size_q;
   logic            usign_q, store_q, wr_q, rmw_rd_q, err_q;
   logic [OB-1:0]   off_q;
   logic [NB-1:0]   bmask_q, wstrb_q;
   logic [AW-1:0]   addr_q;
   logic [XLEN-1:0] wdata_q, rdata_q;
   logic [1:0]      cause_q;

   logic            rdy, accept, illegal_c, mis_c, full_c;
   logic [OB-1:0]   off_c;
   logic [NB-1:0]   smask_c;
   logic [XLEN-1:0] shifted, keep, fmt, bm, merged;
   logic            sb;

   assign rdy    = (state == IDLE) && alive;
   assign accept = rdy && bus.cmd_valid;

   // Command decode feeds only the capture registers, never an output.
   always_comb begin
      off_c   = bus.cmd_addr[OB-1:0];
      smask_c = '0;
      for (int unsigned i = 0; i < NB; i++)
         smask_c[i] = (i < (32'd1 << bus.cmd_size));
      illegal_c = (bus.cmd_read == bus.cmd_write) || (XLEN == 32 && bus.cmd_size == 2'b11);
      case (bus.cmd_size)
         2'b01:   mis_c = bus.cmd_addr[0];
         2'b10:   mis_c = |bus.cmd_addr[1:0];
         2'b11:   mis_c = |bus.cmd_addr[2:0];
         default: mis_c = 1'b0;
      endcase
      full_c = (32'(bus.cmd_size) == OB);
   end

   // Size mask applied before extension; D keeps every bit so extension is a no-op.
   always_comb begin
      shifted = bus.ram_rsp_rdata >> {off_q, 3'b000};
      keep    = '0;
      sb      = 1'b0;
      for (int unsigned i = 0; i < XLEN; i++) begin
         keep[i] = (i < (32'd8 << size_q));
         if (i == (32'd8 << size_q) - 32'd1)
            sb = shifted[i];
      end
      fmt = shifted & keep;
      if (!usign_q && sb)
         fmt = fmt | ~keep;
   end

   always_comb begin
      bm = '0;
      for (int unsigned i = 0; i < XLEN; i++)
         bm[i] = bmask_q[i / 8];
      merged = (rdata_q & ~bm) | (wdata_q & bm);
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (accept) state_n = (illegal_c || mis_c) ? WB : REQ;
         REQ:  if (bus.ram_req_ready) state_n = RSP;
         RSP: begin
            if (bus.ram_rsp_valid)     state_n = rmw_rd_q ? MRG : WB;
            else if (cnt == CW'(TMO))  state_n = WB;
         end
         MRG:  state_n = REQ;
         WB:   if (bus.wbck_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alive    <= 1'b0;
         cnt      <= '0;
         size_q   <= '0;
         usign_q  <= 1'b0;
         store_q  <= 1'b0;
         wr_q     <= 1'b0;
         rmw_rd_q <= 1'b0;
         err_q    <= 1'b0;
         cause_q  <= '0;
         off_q    <= '0;
         bmask_q  <= '0;
         wstrb_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         alive <= 1'b1;
         case (state)
            IDLE: if (accept) begin
               size_q   <= bus.cmd_size;
               usign_q  <= bus.cmd_usign;
               store_q  <= bus.cmd_write;
               off_q    <= off_c;
               bmask_q  <= smask_c << off_c;
               wstrb_q  <= (RMW_MODE != 0) ? '1 : (smask_c << off_c);
               addr_q   <= {bus.cmd_addr[AW-1:OB], {OB{1'b0}}};
               wdata_q  <= bus.cmd_wdata << {off_c, 3'b000};
               wr_q     <= bus.cmd_write && ((RMW_MODE == 0) || full_c);
               rmw_rd_q <= bus.cmd_write && (RMW_MODE != 0) && !full_c;
               rdata_q  <= '0;
               err_q    <= illegal_c || mis_c;
               cause_q  <= illegal_c ? 2'b10 : (mis_c ? 2'b01 : 2'b00);
               cnt      <= '0;
            end
            REQ: cnt <= '0;
            RSP: begin
               if (bus.ram_rsp_valid) begin
                  // Raw read word is parked in rdata_q for the merge; stores return 0.
                  if (!store_q)     rdata_q <= fmt;
                  else if (rmw_rd_q) rdata_q <= bus.ram_rsp_rdata;
               end else if (cnt == CW'(TMO)) begin
                  err_q   <= 1'b1;
                  cause_q <= 2'b11;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            MRG: begin
               wdata_q  <= merged;
               rdata_q  <= '0;
               wr_q     <= 1'b1;
               rmw_rd_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready     = rdy;
   assign bus.ram_req_valid = (state == REQ);
   assign bus.ram_req_wr    = (state == REQ) && wr_q;
   assign bus.ram_req_addr  = addr_q;
   assign bus.ram_req_wdata = wdata_q;
   assign bus.ram_req_wstrb = wstrb_q;
   assign bus.wbck_valid    = (state == WB);
   assign bus.wbck_wdata    = rdata_q;
   assign bus.wbck_err      = err_q;
   assign bus.wbck_cause    = cause_q;
endmodule

// File: tb/tb_lsu_ctrl_pipe.sv
// Bench for lsu_ctrl_pipe: two XLEN=32, TMO=3 instances (strobed RAM and RMW RAM)
// driven through one shared stimulus path and checked against a byte-level model.
module tb_lsu_ctrl_pipe;
   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 32;
   localparam int          TMO  = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsu_ctrl_pipe_if #(.XLEN(XLEN), .AW(AW)) b0 ();
   lsu_ctrl_pipe_if #(.XLEN(XLEN), .AW(AW)) b1 ();

   lsu_ctrl_pipe #(.XLEN(XLEN), .AW(AW), .RMW_MODE(0), .TMO(TMO)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
   lsu_ctrl_pipe #(.XLEN(XLEN), .AW(AW), .RMW_MODE(1), .TMO(TMO)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

   logic        sel, cmd_valid, cmd_read, cmd_write, cmd_usign, req_ready, rsp_valid, wbck_ready;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;

   assign b0.cmd_valid = cmd_valid & ~sel;
   assign b1.cmd_valid = cmd_valid & sel;
   assign b0.cmd_read = cmd_read;   assign b1.cmd_read = cmd_read;
   assign b0.cmd_write = cmd_write; assign b1.cmd_write = cmd_write;
   assign b0.cmd_usign = cmd_usign; assign b1.cmd_usign = cmd_usign;
   assign b0.cmd_size = cmd_size;   assign b1.cmd_size = cmd_size;
   assign b0.cmd_addr = cmd_addr;   assign b1.cmd_addr = cmd_addr;
   assign b0.cmd_wdata = cmd_wdata; assign b1.cmd_wdata = cmd_wdata;
   assign b0.ram_req_ready = req_ready; assign b1.ram_req_ready = req_ready;
   assign b0.ram_rsp_valid = rsp_valid; assign b1.ram_rsp_valid = rsp_valid;
   assign b0.ram_rsp_rdata = rsp_rdata; assign b1.ram_rsp_rdata = rsp_rdata;
   assign b0.wbck_ready = wbck_ready;   assign b1.wbck_ready = wbck_ready;

   logic        o_cmd_ready, o_req_valid, o_req_wr, o_wbck_valid, o_wbck_err;
   logic [31:0] o_req_addr, o_req_wdata, o_wbck_wdata;
   logic [3:0]  o_req_wstrb;
   logic [1:0]  o_wbck_cause;
   assign o_cmd_ready  = sel ? b1.cmd_ready     : b0.cmd_ready;
   assign o_req_valid  = sel ? b1.ram_req_valid : b0.ram_req_valid;
   assign o_req_wr     = sel ? b1.ram_req_wr    : b0.ram_req_wr;
   assign o_req_addr   = sel ? b1.ram_req_addr  : b0.ram_req_addr;
   assign o_req_wdata  = sel ? b1.ram_req_wdata : b0.ram_req_wdata;
   assign o_req_wstrb  = sel ? b1.ram_req_wstrb : b0.ram_req_wstrb;
   assign o_wbck_valid = sel ? b1.wbck_valid    : b0.wbck_valid;
   assign o_wbck_wdata = sel ? b1.wbck_wdata    : b0.wbck_wdata;
   assign o_wbck_err   = sel ? b1.wbck_err      : b0.wbck_err;
   assign o_wbck_cause = sel ? b1.wbck_cause    : b0.wbck_cause;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic        err;
      logic [1:0]  cause;
      logic [31:0] data;
      int          nreq;
      int          lat;
      logic [31:0] wr_data;
      logic [3:0]  wr_strb;
   } exp_t;

   // Byte-array view of memory and command; lat = edges from accept to first writeback cycle.
   function automatic exp_t model(input logic rmw, rd, wr, us, input logic [1:0] sz,
                                  input logic [31:0] addr, wdata, mem, input int d);
      exp_t        e;
      int          n, off;
      logic [7:0]  mb[4];
      logic [7:0]  ob[4];
      logic [31:0] v;
      logic [3:0]  st;
      e = '{default: 0};
      n = 1 << sz;
      off = int'(addr % 4);
      for (int i = 0; i < 4; i++) mb[i] = mem[8*i +: 8];
      if (rd == wr || sz == 2'd3) begin
         e.err = 1'b1; e.cause = 2'b10; e.lat = 1; return e;
      end
      if (addr % n != 0) begin
         e.err = 1'b1; e.cause = 2'b01; e.lat = 1; return e;
      end
      if (d < 0 || d > TMO) begin
         e.err = 1'b1; e.cause = 2'b11; e.nreq = 1; e.lat = TMO + 3; return e;
      end
      if (rd) begin
         v = '0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = mb[off + i];
         if (!us && v[8*n - 1])
            for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
         e.data = v; e.nreq = 1; e.lat = 3 + d;
      end else begin
         st = '0;
         for (int j = 0; j < 4; j++) ob[j] = mb[j];
         for (int i = 0; i < n; i++) begin
            ob[off + i] = wdata[8*i +: 8];
            st[off + i] = 1'b1;
         end
         e.wr_data = {ob[3], ob[2], ob[1], ob[0]};
         e.wr_strb = rmw ? 4'hF : st;
         if (rmw && n < 4) begin e.nreq = 2; e.lat = 6 + 2 * d; end
         else              begin e.nreq = 1; e.lat = 3 + d; end
      end
      return e;
   endfunction

   // One command through the selected DUT with a RAM that answers d cycles into RSP (d<0: never).
   task automatic run_op(input string nm, input logic s, rd, wr, us, input logic [1:0] sz,
                         input logic [31:0] addr, wdata, mem, input int d, input int hold);
      exp_t        e;
      int          cyc, cd, nrq, hc, g;
      logic        pend, last_wr, wbseen, done;
      logic        rq_wr[4];
      logic [31:0] rq_addr[4], rq_data[4], bmask;
      logic [3:0]  rq_strb[4];
      e = model(s, rd, wr, us, sz, addr, wdata, mem, d);
      @(negedge clk);
      sel = s; cmd_read = rd; cmd_write = wr; cmd_usign = us; cmd_size = sz;
      cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
      rsp_valid = 1'b0; wbck_ready = 1'b0; req_ready = 1'b1;
      g = 0;
      while (!o_cmd_ready && g < 20) begin @(negedge clk); g++; end
      chk({nm, ".accept"}, o_cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 1; nrq = 0; hc = 0; cd = 0; pend = 1'b0; last_wr = 1'b0; wbseen = 1'b0; done = 1'b0;
      while (!done && cyc < 80) begin
         rsp_valid = 1'b0;
         if (pend) begin
            if (cd == 0) begin
               rsp_valid = 1'b1;
               rsp_rdata = last_wr ? $urandom : mem;
               pend = 1'b0;
            end else cd--;
         end
         if (o_req_valid && req_ready) begin
            if (nrq < 4) begin
               rq_wr[nrq] = o_req_wr; rq_addr[nrq] = o_req_addr;
               rq_data[nrq] = o_req_wdata; rq_strb[nrq] = o_req_wstrb;
            end
            last_wr = o_req_wr;
            nrq++;
            if (d >= 0) begin pend = 1'b1; cd = d; end
         end
         if (o_wbck_valid) begin
            if (!wbseen) begin
               wbseen = 1'b1;
               chk({nm, ".latency"}, cyc, e.lat);
            end
            chk({nm, ".wb_data"}, o_wbck_wdata, e.data);
            chk({nm, ".wb_err"}, o_wbck_err, e.err);
            chk({nm, ".wb_cause"}, o_wbck_cause, e.cause);
            if (hc == hold) begin wbck_ready = 1'b1; done = 1'b1; end
            hc++;
         end else if (wbseen) begin
            break;
         end
         if (!done) begin @(negedge clk); cyc++; end
      end
      chk({nm, ".wb_done"}, done, 1'b1);
      @(negedge clk);
      wbck_ready = 1'b0; rsp_valid = 1'b0;
      chk({nm, ".wb_drop"}, o_wbck_valid, 1'b0);
      chk({nm, ".nreq"}, nrq, e.nreq);
      for (int i = 0; i < nrq && i < 2; i++) begin
         chk({nm, ".req_addr"}, rq_addr[i], addr & ~32'h3);
         chk({nm, ".req_wr"}, rq_wr[i], wr && !e.err && (i == e.nreq - 1));
         if (s) chk({nm, ".req_strb"}, rq_strb[i], 4'hF);
         if (wr && !e.err && i == e.nreq - 1) begin
            for (int b = 0; b < 4; b++) bmask[8*b +: 8] = {8{e.wr_strb[b]}};
            chk({nm, ".req_strb"}, rq_strb[i], e.wr_strb);
            chk({nm, ".req_data"}, rq_data[i] & bmask, e.wr_data & bmask);
         end
      end
   endtask

   task automatic chk_idle_zero(input string nm);
      chk({nm, ".cmd_ready"}, o_cmd_ready, 1'b0);
      chk({nm, ".req_valid"}, o_req_valid, 1'b0);
      chk({nm, ".wbck_valid"}, o_wbck_valid, 1'b0);
      chk({nm, ".wbck_err"}, o_wbck_err, 1'b0);
      chk({nm, ".wbck_cause"}, o_wbck_cause, 2'b00);
      chk({nm, ".buses"}, {o_wbck_wdata, o_req_wdata} | 64'(o_req_addr) | 64'(o_req_wstrb), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        s, rd, wr, us;
      logic [1:0]  sz;
      logic [31:0] addr;
      int          r, d;
      rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_write = 1'b0;
      cmd_usign = 1'b0; cmd_size = 2'b00; cmd_addr = '0; cmd_wdata = '0;
      req_ready = 1'b1; rsp_valid = 1'b0; rsp_rdata = '0; wbck_ready = 1'b0;
      repeat (3) @(negedge clk);
      sel = 1'b0; #1 chk_idle_zero("rst0");
      sel = 1'b1; #1 chk_idle_zero("rst1");
      @(negedge clk);
      rst = 1'b0;
      #1 chk("ready_before_edge", o_cmd_ready, 1'b0);
      @(negedge clk);
      chk("ready_after_edge", o_cmd_ready, 1'b1);

      run_op("lb_signed",  1'b0, 1, 0, 0, 2'd0, 32'h3, 32'h0, 32'h80FF_0102, 0, 0);
      run_op("lhu",        1'b0, 1, 0, 1, 2'd1, 32'h2, 32'h0, 32'h80FF_0102, 1, 0);
      run_op("lh_signed",  1'b0, 1, 0, 0, 2'd1, 32'h2, 32'h0, 32'h80FF_0102, 0, 0);
      run_op("lw",         1'b0, 1, 0, 0, 2'd2, 32'h104, 32'h0, 32'hDEAD_BEEF, 2, 0);
      run_op("sh_strobe",  1'b0, 0, 1, 0, 2'd1, 32'h2, 32'h0000_ABCD, 32'h0, 0, 0);
      run_op("sb_rmw",     1'b1, 0, 1, 0, 2'd0, 32'h1, 32'h55, 32'h1122_3344, 0, 0);
      run_op("sw_rmw_full",1'b1, 0, 1, 0, 2'd2, 32'h8, 32'hCAFE_F00D, 32'h0, 0, 0);
      run_op("lw_misalign",1'b0, 1, 0, 0, 2'd2, 32'h2, 32'h0, 32'h0, 0, 0);
      run_op("rw_both",    1'b0, 1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 0);
      run_op("rw_none",    1'b1, 0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 0);
      run_op("size_d",     1'b0, 1, 0, 0, 2'd3, 32'h3, 32'h0, 32'h0, 0, 0);
      run_op("tmo_never",  1'b0, 1, 0, 0, 2'd2, 32'h0, 32'h0, 32'h1234_5678, -1, 0);
      run_op("tmo_edge",   1'b0, 1, 0, 0, 2'd2, 32'h0, 32'h0, 32'h1234_5678, TMO, 0);
      run_op("tmo_late",   1'b0, 1, 0, 0, 2'd2, 32'h0, 32'h0, 32'h1234_5678, TMO + 1, 0);
      run_op("tmo_rmw",    1'b1, 0, 1, 0, 2'd0, 32'h2, 32'h77, 32'h0, -1, 0);
      run_op("backpress",  1'b0, 1, 0, 0, 2'd0, 32'h1, 32'h0, 32'h0000_8100, 0, 5);

      for (int k = 0; k < 40; k++) begin
         s = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         rd = 1'($urandom_range(0, 1));
         wr = (r == 0) ? rd : ~rd;
         us = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
         d = $urandom_range(0, 2);
         run_op("rand", s, rd, wr, us, sz, addr, $urandom, $urandom, d, $urandom_range(0, 2));
      end

      // Reset in RSP with the response still outstanding.
      @(negedge clk);
      sel = 1'b0; cmd_read = 1'b1; cmd_write = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h40;
      cmd_valid = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; wbck_ready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("mid.req_valid", o_req_valid, 1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_idle_zero("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rsp_valid = 1'b1; rsp_rdata = 32'hA5A5_A5A5;
      @(negedge clk);
      rsp_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("late_rsp.wbck_valid", o_wbck_valid, 1'b0);
         chk("late_rsp.req_valid", o_req_valid, 1'b0);
         chk("late_rsp.cmd_ready", o_cmd_ready, 1'b1);
         @(negedge clk);
      end
      run_op("post_reset", 1'b0, 1, 0, 1, 2'd0, 32'h2, 32'h0, 32'h00C3_0000, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
